// File: rtl/ecc_pkg.sv
// Shared Hamming SEC code definition used by both the stream encoder and the corrector.
// Positions 1..N, check bit i at 2^i, data bits fill the remaining positions in ascending order.
package ecc_pkg;

    typedef enum logic {
        IDLE,
        ARMED
    } inj_state_e;

    function automatic int ecc_width(input int dw);
        int r;
        r = 0;
        for (int k = 7; k >= 1; k--) begin
            if ((1 << k) >= dw + k + 1) r = k;
        end
        return r;
    endfunction

    function automatic logic is_pow2(input int p);
        return (p > 0) && ((p & (p - 1)) == 0);
    endfunction

    // Only meaningful for non-power-of-two positions.
    function automatic int pos_to_data_idx(input int pos);
        int n;
        n = 0;
        for (int i = 0; i < 7; i++) begin
            if ((1 << i) <= pos) n++;
        end
        return pos - 1 - n;
    endfunction

    function automatic logic [63:0] ecc_data_mask(input int dw, input int chk);
        logic [63:0] m;
        int          r;
        m = '0;
        r = ecc_width(dw);
        for (int p = 3; p <= dw + r; p++) begin
            if (!is_pow2(p) && (((p >> chk) & 1) != 0))
                m = m | (64'd1 << pos_to_data_idx(p));
        end
        return m;
    endfunction

endpackage

// File: rtl/ecc_encoder_stream_if.sv
// Input and output valid/ready streams of the ECC encoder.
// The slave modport is the encoder's view; the master modport is the surrounding logic's view.
interface ecc_encoder_stream_if #(
    parameter int DATA_WIDTH = 32
);
    import ecc_pkg::*;

    localparam int ECC_WIDTH = ecc_width(DATA_WIDTH);

    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [ECC_WIDTH-1:0]  m_ecc;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_ecc
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_ecc
    );

endinterface

// File: rtl/ecc_parity_gen.sv
// Combinational data -> check-bit generator; each check bit is the even parity of its
// covered data bits. Also reused by the corrector for syndrome generation.
module ecc_parity_gen
    import ecc_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int ECC_WIDTH  = ecc_width(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [ECC_WIDTH-1:0]  ecc_o
);

    for (genvar g = 0; g < ECC_WIDTH; g++) begin : g_chk
        localparam logic [63:0] MASK = ecc_data_mask(DATA_WIDTH, g);
        assign ecc_o[g] = ^(data_i & MASK[DATA_WIDTH-1:0]);
    end

endmodule

// File: rtl/ecc_encoder_stream.sv
// Streaming Hamming SEC encoder: output register plus skid register, one-cycle latency,
// with a one-shot single-bit error injector applied after check-bit generation.
//   state | meaning
//   IDLE  | no injection pending
//   ARMED | next accepted word gets codeword position pos_q flipped
module ecc_encoder_stream
    import ecc_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int CNT_WIDTH  = 16,
    localparam int ECC_WIDTH  = ecc_width(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    ecc_encoder_stream_if.slave    bus,
    input  logic                   inj_arm,
    input  logic [ECC_WIDTH-1:0]   inj_pos,
    output logic                   inj_done,
    output logic [CNT_WIDTH-1:0]   word_cnt
);

    localparam int N = DATA_WIDTH + ECC_WIDTH;

    inj_state_e              state_q, state_d;
    logic [ECC_WIDTH-1:0]    pos_q, pos_d;
    logic                    corrupt;

    logic                    ready_q, ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [ECC_WIDTH-1:0]    out_ecc_q, out_ecc_d;
    logic                    skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0]   skid_data_q, skid_data_d;
    logic [ECC_WIDTH-1:0]    skid_ecc_q, skid_ecc_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

    logic                    in_fire, out_fire;
    logic [ECC_WIDTH-1:0]    ecc_raw, ecc_flip;
    logic [DATA_WIDTH-1:0]   data_flip, word_data;
    logic [ECC_WIDTH-1:0]    word_ecc;

    assign in_fire  = bus.s_valid && ready_q && !rst;
    assign out_fire = out_valid_q && bus.m_ready;

    ecc_parity_gen #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .data_i (bus.s_data),
        .ecc_o  (ecc_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
        end
    end

    // A re-arm while ARMED keeps the injector pending even if a word is consumed that cycle.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        if (inj_arm) begin
            pos_d   = inj_pos;
            state_d = ARMED;
        end else if (state_q == ARMED && in_fire) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        corrupt  = (state_q == ARMED) && in_fire;
        inj_done = corrupt;
    end

    // Out-of-range positions leave both masks empty so the word passes clean.
    always_comb begin
        data_flip = '0;
        ecc_flip  = '0;
        if (inj_pos_valid(pos_q)) begin
            if (is_pow2(int'(pos_q))) begin
                for (int i = 0; i < ECC_WIDTH; i++) begin
                    if (int'(pos_q) == (1 << i)) ecc_flip = ECC_WIDTH'(1) << i;
                end
            end else begin
                data_flip = DATA_WIDTH'(1) << pos_to_data_idx(int'(pos_q));
            end
        end
    end

    function automatic logic inj_pos_valid(input logic [ECC_WIDTH-1:0] p);
        return (p != '0) && (int'(p) <= N);
    endfunction

    assign word_data = corrupt ? (bus.s_data ^ data_flip) : bus.s_data;
    assign word_ecc  = corrupt ? (ecc_raw ^ ecc_flip) : ecc_raw;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_ecc_d    = out_ecc_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ecc_d   = skid_ecc_q;
        if (!out_valid_q || out_fire) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_ecc_d    = skid_ecc_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_data_d  = word_data;
                out_ecc_d   = word_ecc;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_data_d  = word_data;
            skid_ecc_d   = word_ecc;
            skid_valid_d = 1'b1;
        end
        ready_d = !skid_valid_d;
        cnt_d   = (in_fire && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q      <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ecc_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ecc_q   <= '0;
            cnt_q        <= '0;
        end else begin
            ready_q      <= ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ecc_q    <= out_ecc_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ecc_q   <= skid_ecc_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.s_ready = ready_q;
    assign bus.m_valid = out_valid_q;
    assign bus.m_data  = out_data_q;
    assign bus.m_ecc   = out_ecc_q;
    assign word_cnt    = cnt_q;

endmodule

// File: tb/tb_ecc_encoder_stream.sv
// Directed bench for ecc_encoder_stream (DATA_WIDTH 32): encoding vectors, skid behaviour
// under backpressure, error injection corner cases and reset while busy.
module tb_ecc_encoder_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        inj_arm;
    logic [5:0]  inj_pos;
    logic        inj_done;
    logic [15:0] word_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    ecc_encoder_stream_if #(.DATA_WIDTH(32)) bus ();

    ecc_encoder_stream #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .inj_arm  (inj_arm),
        .inj_pos  (inj_pos),
        .inj_done (inj_done),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Check bits = XOR of the positions of all set data bits.
    function automatic logic [5:0] ref_ecc(input logic [31:0] d);
        logic [5:0] e;
        int         di;
        e  = '0;
        di = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (d[di]) e = e ^ p[5:0];
                di++;
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;
        inj_arm     = 1'b0;
        inj_pos     = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] t1_d [4] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [5:0]  t1_e [4] = '{6'b000000, 6'b000011, 6'b011000, 6'b100110};
    logic [3:0]  rdy_pat  = 4'b1001;
    int          sent, recv, occ, cyc;
    logic        acc, ofire;

    initial begin
        // reset state
        rst = 1'b1; bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
        inj_arm = 1'b0; inj_pos = '0;
        tick();
        tick();
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_ecc", bus.m_ecc, 0);
        chk("rst_inj_done", inj_done, 0);
        rst = 1'b0;

        // back-to-back encoding vectors, one cycle latency
        for (int i = 0; i < 4; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = t1_d[i];
            tick();
            chk("enc_m_valid", bus.m_valid, 1);
            chk("enc_m_data", bus.m_data, t1_d[i]);
            chk("enc_m_ecc", bus.m_ecc, t1_e[i]);
            chk("enc_s_ready", bus.s_ready, 1);
        end
        bus.s_valid = 1'b0;
        tick();
        chk("enc_drained", bus.m_valid, 0);
        chk("enc_word_cnt", word_cnt, 4);

        // 8 words with m_ready toggling 1-0-0-1
        do_reset();
        sent = 0; recv = 0; occ = 0; cyc = 0;
        while (recv < 8 && cyc < 40) begin
            bus.m_ready = rdy_pat[cyc % 4];
            bus.s_valid = (sent < 8);
            bus.s_data  = 32'hA0 + sent;
            #1;
            chk("bp_s_ready", bus.s_ready, (occ < 2));
            chk("bp_m_valid", bus.m_valid, (occ > 0));
            acc   = bus.s_valid && bus.s_ready;
            ofire = bus.m_valid && bus.m_ready;
            if (ofire) begin
                chk("bp_order_data", bus.m_data, 32'hA0 + recv);
                chk("bp_order_ecc", bus.m_ecc, ref_ecc(32'hA0 + recv));
                recv++;
            end
            if (acc) sent++;
            occ = occ + int'(acc) - int'(ofire);
            tick();
            cyc++;
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        chk("bp_recv_count", recv, 8);
        chk("bp_word_cnt", word_cnt, 8);
        tick();
        chk("bp_empty", bus.m_valid, 0);

        // inject at position 3 -> data[0]
        inj_arm = 1'b1; inj_pos = 6'd3;
        tick();
        inj_arm = 1'b0;
        chk("inj3_no_done_on_arm", inj_done, 0);
        bus.s_valid = 1'b1; bus.s_data = 32'h0;
        #1;
        chk("inj3_done", inj_done, 1);
        tick();
        chk("inj3_m_data", bus.m_data, 32'h1);
        chk("inj3_m_ecc", bus.m_ecc, 6'b000000);
        chk("inj3_done_once", inj_done, 0);
        tick();
        chk("inj3_next_clean", bus.m_data, 32'h0);
        bus.s_valid = 1'b0;
        tick();

        // inject at position 4 -> ecc[2]
        inj_arm = 1'b1; inj_pos = 6'd4;
        tick();
        inj_arm = 1'b0;
        bus.s_valid = 1'b1; bus.s_data = 32'h1;
        tick();
        bus.s_valid = 1'b0;
        chk("inj4_m_data", bus.m_data, 32'h1);
        chk("inj4_m_ecc", bus.m_ecc, 6'b000111);
        tick();

        // out-of-range position: clean word, done still pulses
        inj_arm = 1'b1; inj_pos = 6'd39;
        tick();
        inj_arm = 1'b0;
        bus.s_valid = 1'b1; bus.s_data = 32'h1234_5678;
        #1;
        chk("inj39_done", inj_done, 1);
        tick();
        bus.s_valid = 1'b0;
        chk("inj39_m_data", bus.m_data, 32'h1234_5678);
        chk("inj39_m_ecc", bus.m_ecc, ref_ecc(32'h1234_5678));
        chk("inj39_back_idle", inj_done, 0);
        tick();

        // arm in the same cycle as an accepted word
        inj_arm = 1'b1; inj_pos = 6'd5;
        bus.s_valid = 1'b1; bus.s_data = 32'h0;
        #1;
        chk("same_cyc_no_done", inj_done, 0);
        tick();
        inj_arm = 1'b0;
        chk("same_cyc_clean", bus.m_data, 32'h0);
        #1;
        chk("same_cyc_next_done", inj_done, 1);
        tick();
        bus.s_valid = 1'b0;
        chk("same_cyc_next_data", bus.m_data, 32'h2);
        chk("same_cyc_next_ecc", bus.m_ecc, 6'b000000);
        tick();

        // reset with skid full and injector armed
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1; bus.s_data = 32'h11;
        tick();
        bus.s_data = 32'h22;
        tick();
        bus.s_valid = 1'b0;
        inj_arm = 1'b1; inj_pos = 6'd3;
        tick();
        inj_arm = 1'b0;
        chk("full_s_ready", bus.s_ready, 0);
        rst = 1'b1;
        tick();
        chk("rst2_m_valid", bus.m_valid, 0);
        chk("rst2_s_ready", bus.s_ready, 1);
        chk("rst2_word_cnt", word_cnt, 0);
        rst = 1'b0;
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1; bus.s_data = 32'h5;
        #1;
        chk("rst2_idle", inj_done, 0);
        tick();
        bus.s_valid = 1'b0;
        chk("rst2_clean_data", bus.m_data, 32'h5);
        chk("rst2_clean_ecc", bus.m_ecc, ref_ecc(32'h5));
        chk("rst2_word_cnt1", word_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ecc_encoder_stream.md
Name: ecc_encoder_stream

Overview:
- Streaming Hamming SEC encoder that sits directly upstream of the ecc corrector.
- Accepts data words over a valid/ready handshake and computes the check-bit group (in_ham_gr of the corrector).
- Emits {data, ecc} over a registered valid/ready output with full throughput.
- Includes a one-shot single-bit error injector so the corrector's correction path can be exercised in-system.

Parameters:
- DATA_WIDTH, 32, data bits per word (8..57).
- ECC_WIDTH, derived in the package: smallest r with 2^r >= DATA_WIDTH + r + 1 (32 gives 6, 8 gives 4). Not user-overridable.
- CNT_WIDTH, 16, width of the accepted-word counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  block can accept a word.
- s_data  in  DATA_WIDTH  input data.
- inj_arm  in  1  single-cycle pulse that arms the injector.
- inj_pos  in  ECC_WIDTH  codeword position to flip (1..DATA_WIDTH+ECC_WIDTH), sampled with inj_arm.
- inj_done  out  1  one-cycle pulse when an injected word is accepted at the input.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts.
- m_data  out  DATA_WIDTH  data to the corrector.
- m_ecc  out  ECC_WIDTH  check bits to the corrector.
- word_cnt  out  CNT_WIDTH  count of accepted input words, saturating.

Behaviour:
- Code definition:
  - Codeword positions run 1..N, with N = DATA_WIDTH + ECC_WIDTH.
  - Check bit i sits at position 2^i.
  - Data bits fill the non-power-of-two positions in ascending order; data[0] is at position 3.
  - ecc[i] = XOR of all data bits whose position has bit i set (even parity).
- Handshake:
  - Input transfer occurs when s_valid && s_ready.
  - Output transfer occurs when m_valid && m_ready.
  - m_data, m_ecc and m_valid hold stable while m_valid && !m_ready.
- Pipeline:
  - One output register plus one skid register.
  - Latency 1 cycle (accept at edge k, m_valid at k+1).
  - Throughput 1 word/cycle while m_ready = 1.
  - s_ready = !skid_full, registered; no combinational path from m_ready to s_ready.
  - Skid fills when an input is accepted while the output register is valid and stalled.
  - Skid drains into the output register on the next output transfer.
  - Ordering is strictly FIFO.
- Injector FSM:
  - IDLE: inj_arm latches inj_pos and moves to ARMED. A word accepted in the same cycle is NOT corrupted.
  - ARMED: the next accepted word is corrupted, inj_done pulses the same cycle, return to IDLE.
  - ARMED: inj_arm re-latches inj_pos and stays ARMED; if a word is accepted that cycle it uses the old pos.
  - Corruption is applied after ecc computation. A power-of-two position 2^i flips m_ecc[i]; any other position flips the mapped data bit.
  - inj_pos = 0 or inj_pos > N: the word passes unmodified, but inj_done still pulses and the FSM returns to IDLE.
- word_cnt increments on each input transfer and saturates at all-ones.
- Reset (rst high at an edge):
  - m_valid = 0, skid empty, s_ready = 1, FSM = IDLE, inj_done = 0, word_cnt = 0, m_data = 0, m_ecc = 0.
  - Words in flight are discarded.
  - Input is not accepted on any cycle where rst is high.

Decomposition:
- ecc_pkg: ecc_width() function, position-to-data-index mapping function, is_pow2 helper, injector state enum (IDLE, ARMED). This package is shared with the ecc corrector so both sides use one code definition.
- Sub-module ecc_parity_gen: combinational data -> ecc generator, also instantiated by the corrector for syndrome generation.

Test Plan:
- Reset, then stream s_data = 0, 1, 0xFFFFFFFF, 0x80000000 with m_ready = 1 -> m_ecc = 6'b000000, 6'b000011, 6'b011000, 6'b100110, each 1 cycle after acceptance, back-to-back.
- Stream 8 words with m_ready toggling 1-0-0-1 -> no word lost or duplicated; s_ready drops only while the skid is full; output order matches input; word_cnt = 8.
- inj_arm with inj_pos = 3, then send 0x00000000 -> m_data = 0x00000001, m_ecc = 6'b000000, inj_done pulses once; the next word passes clean.
- inj_arm with inj_pos = 4, then send 0x00000001 -> m_data = 0x00000001, m_ecc = 6'b000111.
- inj_arm with inj_pos = 39 -> the next word passes unmodified and inj_done pulses. Separately, inj_arm in the same cycle as an accepted word -> that word is clean and the following word is corrupted.
- Assert rst while the skid is full and the injector is ARMED -> next cycle m_valid = 0, s_ready = 1, word_cnt = 0, FSM IDLE; the next word is uncorrupted.
